// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that merges NREQ byte streams into one registered
//   byte stream feeding a UART transmit FIFO write path. An owner keeps the
//   grant until it sends a newline (0x0A) or stays idle for TIMEOUT cycles.
//
//   Build option: define UART_ARB_TAG_EN to prefix every grant with an owner
//   tag "<digit>:" (0x30+owner, 0x3A). Undefined by default, and then the
//   tag states are not built at all.
//
// Ports
//   clock         sole clock, rising edge
//   async_resetn  asynchronous active-low reset
//   req_valid     [NREQ]   per-requester byte valid
//   req_data      [8*NREQ] per-requester byte, requester i on [8i+7:8i]
//   req_ready     [NREQ]   per-requester accept
//   out_valid     registered byte valid toward the FIFO
//   out_data      [8]      registered byte
//   out_ready     downstream accept
//   grant         [NREQ]   one-hot current owner, zero in IDLE
//   busy          high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick next valid requester round-robin from last+1
// TAG0  | (tag build) load owner digit 0x30+g into the output buffer
// TAG1  | (tag build) load ':' into the output buffer
// PASS  | forward owner bytes; leave on 0x0A or on idle timeout
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              async_resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int              IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW-1:0] LAST_RST   = IDXW'(NREQ - 1);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NREQ - 1);
    localparam logic [23:0]     TIMEOUT_M1 = 24'(TIMEOUT - 1);
    localparam logic [7:0]      NEWLINE    = 8'h0A;

`ifdef UART_ARB_TAG_EN
    localparam logic [7:0]      TAG_BASE   = 8'h30;
    localparam logic [7:0]      TAG_COLON  = 8'h3A;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG0 = 2'd1,
        TAG1 = 2'd2,
        PASS = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] last_nxt;
    logic [23:0]     idle_cnt;
    logic [23:0]     idle_cnt_nxt;
    logic            load;
    logic [7:0]      load_data;
    logic            buffer_free;
    logic            owner_valid;
    logic [7:0]      owner_data;
    logic [IDXW-1:0] sel_idx;
    logic            sel_found;
    logic [IDXW-1:0] cand;

    assign buffer_free = !out_valid || out_ready;
    assign busy        = (state != IDLE);
    // last always holds the current owner while granted
    assign owner_valid = req_valid[last];
    assign owner_data  = req_data[{last, 3'b000} +: 8];

    // Round-robin search starting just after the previous owner.
    always_comb begin
        sel_idx   = last;
        sel_found = 1'b0;
        cand      = last;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDXW'(1);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_nxt     = last;
        idle_cnt_nxt = idle_cnt;
        load         = 1'b0;
        load_data    = owner_data;
        req_ready    = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt          = '0;
                    grant_nxt[sel_idx] = 1'b1;
                    last_nxt           = sel_idx;
                    idle_cnt_nxt       = '0;
`ifdef UART_ARB_TAG_EN
                    state_nxt          = TAG0;
`else
                    state_nxt          = PASS;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG0: begin
                if (buffer_free) begin
                    load      = 1'b1;
                    load_data = TAG_BASE + 8'(last);
                    state_nxt = TAG1;
                end
            end
            TAG1: begin
                if (buffer_free) begin
                    load         = 1'b1;
                    load_data    = TAG_COLON;
                    idle_cnt_nxt = '0;
                    state_nxt    = PASS;
                end
            end
`endif
            PASS: begin
                req_ready[last] = buffer_free;
                if (owner_valid) begin
                    // a valid owner stalled by the buffer is not idle
                    idle_cnt_nxt = '0;
                    if (buffer_free) begin
                        load = 1'b1;
                        if (owner_data == NEWLINE) begin
                            state_nxt = IDLE;
                            grant_nxt = '0;
                        end
                    end
                end else begin
                    // counter lands on TIMEOUT on the same edge the grant drops
                    idle_cnt_nxt = idle_cnt + 24'd1;
                    if (idle_cnt == TIMEOUT_M1) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            grant     <= '0;
            last      <= LAST_RST;
            idle_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            grant    <= grant_nxt;
            last     <= last_nxt;
            idle_cnt <= idle_cnt_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of byte-stream requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 1000000, consecutive idle cycles of the owner before its grant is released; legal range 1..2^24-1.
REQ-003 Port clock  input  1  sole clock; all flops on rising edge.
REQ-004 Port async_resetn  input  1  reset, asynchronous assert, active-low; every flop clears immediately while low.
REQ-005 Port req_valid  input  NREQ  per-requester byte valid.
REQ-006 Port req_data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 Port req_ready  output  NREQ  per-requester accept; a byte transfers when valid and ready are both high.
REQ-008 Port out_valid  output  1  registered byte valid toward the UART transmit FIFO write path.
REQ-009 Port out_data  output  8  registered byte.
REQ-010 Port out_ready  input  1  downstream accept; a byte leaves when out_valid and out_ready are both high.
REQ-011 Port grant  output  NREQ  one-hot current owner; all zero in IDLE.
REQ-012 Port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The arbiter SHALL implement states IDLE, TAG0, TAG1, PASS; TAG0/TAG1 exist only per REQ-030.
REQ-014 In IDLE, when any req_valid is high, the arbiter SHALL select the first requester with valid high, searching round-robin from last+1 upward with wrap at NREQ-1 to 0, register it into grant and last, and advance to TAG0 (tags enabled) or PASS.
REQ-015 Selection SHALL take exactly one cycle; req_ready SHALL be all zero in IDLE.
REQ-016 Output buffer is one entry: buffer_free = !out_valid || out_ready.
REQ-017 In PASS, req_ready[g] SHALL equal buffer_free for owner g; all other req_ready SHALL be 0.
REQ-018 An accepted byte SHALL appear on out_data with out_valid high on the next cycle (latency 1); back-to-back acceptance SHALL sustain one byte per cycle while out_ready stays high.
REQ-019 out_valid SHALL clear on the cycle after out_valid&&out_ready unless a new byte is loaded the same cycle.
REQ-020 Acceptance of byte 0x0A from the owner SHALL move the state to IDLE on that edge; grant SHALL go to zero the next cycle; the 0x0A byte itself SHALL still be output.
REQ-021 In PASS, a 24-bit idle counter SHALL increment each cycle req_valid[g] is low, clear on any cycle req_valid[g] is high, and clear on entry to PASS.
REQ-022 Stall by out_ready low while req_valid[g] is high SHALL NOT advance the idle counter.
REQ-023 When the idle counter reaches TIMEOUT, the state SHALL move to IDLE on that edge, with no byte accepted that cycle.
REQ-024 Requests arriving while another requester owns the grant SHALL be held off (ready 0) without loss; a requester SHALL NOT be granted twice in a row if another valid requester is waiting.
REQ-025 A byte held in the output buffer at grant release SHALL be delivered unchanged before any tag or byte of the next owner.

Reset
REQ-026 While async_resetn is low: state IDLE, grant 0, busy 0, req_ready 0, out_valid 0, out_data 0x00, idle counter 0, last = NREQ-1 (so requester 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL drop the buffered byte; no partial state SHALL survive deassertion.
REQ-028 The first arbitration SHALL occur no earlier than the first rising clock edge after async_resetn goes high.

Configuration
REQ-029 Macro UART_ARB_TAG_EN SHALL control owner tagging.
REQ-030 When defined, after each grant the arbiter SHALL emit 0x30+g in TAG0 and 0x3A (':') in TAG1, each loaded when buffer_free, then enter PASS; req_ready SHALL be 0 in TAG0/TAG1; the idle counter SHALL NOT run in TAG0/TAG1.
REQ-031 When not defined, TAG0/TAG1 logic SHALL be absent and IDLE SHALL go directly to PASS.

Verification
REQ-032 Reset release, req_valid=2'b11, both send "A\n", out_ready=1, tags off -> out stream 0x41,0x0A,0x41,0x0A; grant 01 then 10.
REQ-033 Owner 0 sends 0x41 then drops valid, TIMEOUT=16 -> grant released exactly 16 cycles after valid drops; requester 1 then granted.
REQ-034 out_ready held low 100 cycles with owner valid high -> out_valid held with byte unchanged, idle counter stays 0, no release.
REQ-035 UART_ARB_TAG_EN defined, requester 1 sends "x\n" -> out stream 0x31,0x3A,0x78,0x0A.
REQ-036 async_resetn pulsed low while out_valid=1 mid-line -> out_valid, grant, busy go 0 immediately; after release, requester 0 wins over simultaneous requester 1.
